// File: rtl/wide_add_sequencer_pkg.sv
// wide_add_pkg: definitions shared by the wide adder sequencer.
//   - wadd_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   - WADD_WIDTH   : default total operand/sum width
//   - WADD_CHUNK   : default width of the shared adder slice
package wide_add_pkg;

    localparam int WADD_WIDTH = 128;
    localparam int WADD_CHUNK = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wadd_state_t;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if: operand and result handshakes of the wide adder.
//   in_valid/in_ready : operand pair (a, b, cin) handshake, producer -> adder
//   out_valid/out_ready: result (sum, cout) handshake, adder -> consumer
// Modports:
//   master : the side that drives operands and accepts results (testbench/system)
//   slave  : the adder itself
interface wide_add_sequencer_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/wide_add_sequencer_add_slice.sv
// add_slice: purely combinational CHUNK-bit adder with carry in/out.
//   a, b : CHUNK-bit addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, low CHUNK bits
//   cout : carry out of bit CHUNK-1
module add_slice #(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle WIDTH-bit adder built from one shared
// CHUNK-bit slice, processed least significant chunk first, one per cycle.
// The carry between chunks is registered, so there is no wide carry chain.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of wide_add_sequencer_if (operand and result handshakes)
// Timing: accept edge is edge 0, out_valid rises after edge NUM_CHUNKS,
// in_ready is only high in IDLE so accepts never overlap a result handshake.
// WIDTH must be a multiple of CHUNK with at least two chunks.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = WADD_WIDTH,
    parameter int CHUNK = WADD_CHUNK
) (
    input logic                 clk,
    input logic                 reset,
    wide_add_sequencer_if.slave bus
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = $clog2(NUM_CHUNKS);

    wadd_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Chunk views of the latched operands; the slice inputs are muxed by idx.
    logic [CHUNK-1:0] a_chunk [NUM_CHUNKS];
    logic [CHUNK-1:0] b_chunk [NUM_CHUNKS];

    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
        assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
        assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
    end

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    add_slice #(
        .CHUNK (CHUNK)
    ) u_add_slice (
        .a    (a_chunk[idx_q]),
        .b    (b_chunk[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Only the chunk selected by idx is overwritten; the others
                // keep whatever they held before.
                for (int i = 0; i < NUM_CHUNKS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == IDX_W'(NUM_CHUNKS - 1)) begin
                    cout_d  = slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide adder controller. Sequences one shared 32-bit carry-in/carry-out adder slice across the chunks of a WIDTH-bit operand pair, least significant chunk first, one chunk per cycle.
- The carry is registered between chunks.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.
- Gives wide additions, for example 128-bit, without a wide combinational carry chain.

Parameters:
- WIDTH, 128, total operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 32, width of the shared adder slice.
- NUM_CHUNKS, WIDTH/CHUNK, derived localparam and not overridable. Must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a, b, cin is valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, chunk index=0, carry register=0, operand registers=0.
- Reset mid-operation: the in-flight addition is discarded with no partial result. The block is in IDLE on the next cycle. A pending out_valid is dropped.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, latch a, b and cin. Set the carry register to cin, idx=0, state->RUN.
  - Operands are sampled only on this accept edge. Later changes on a, b or cin have no effect.
- RUN:
  - in_ready=0 and out_valid=0.
  - Each cycle, the slice computes A[idx*CHUNK +: CHUNK] + B[same] + carry register.
  - The slice sum is written into sum[idx*CHUNK +: CHUNK] and the slice carry-out goes into the carry register.
  - If idx==NUM_CHUNKS-1: cout is set to the slice carry-out, idx resets to 0, state->DONE. Otherwise idx increments.
- DONE:
  - out_valid=1 and in_ready=0. sum and cout are stable while out_valid=1 && !out_ready.
  - On out_ready: state->IDLE and out_valid deasserts on the next cycle.
- Latency: the accept edge is edge 0. out_valid is first high after edge NUM_CHUNKS (4 cycles at the defaults).
- Throughput: one addition per NUM_CHUNKS+2 cycles minimum (accept, NUM_CHUNKS RUN cycles, handshake).
- No overlap: a new operand pair is not accepted in the same cycle as a result handshake. in_ready is asserted only in IDLE.
- sum contents in RUN: chunks not yet computed keep their previous values. The consumer must ignore sum and cout unless out_valid=1.
- Arithmetic: the result is unsigned modulo 2^WIDTH. Signed overflow detection is out of scope.
- Backpressure: out_ready held low keeps the block in DONE indefinitely. in_valid is ignored throughout.
- Idle behaviour: out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package wide_add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} wadd_state_t.
  - Default localparams WADD_WIDTH=128 and WADD_CHUNK=32.
- One sub-module, add_slice: a purely combinational CHUNK-bit adder.
  - Inputs: a, b, cin. Outputs: sum, cout.
  - Instantiated exactly once. The chunk select is a muxed part-select driven by idx.
- All state, the idx counter and the carry register live in wide_add_sequencer.

Test Plan:
- Basic add: a=1, b=2, cin=0, out_ready held 1 -> out_valid high exactly 4 cycles after accept; sum=3, cout=0. in_ready low from accept until the cycle after the handshake.
- Full-width carry ripple: a=2^128-1, b=0, cin=1 -> sum=0, cout=1. Checks the carry crossing every chunk boundary.
- Chunk-boundary carry: a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1, cin=0 -> sum=0x...0001_0000_0000, cout=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid, while a and b change and in_valid=1 -> sum and cout stable, in_ready=0, no new accept. Asserting out_ready completes the handshake and in_ready=1 on the next cycle.
- Reset mid-RUN: assert reset at idx=2 -> next cycle state=IDLE, out_valid=0, sum=0, cout=0, in_ready=1. A following add of 5+7 returns 12.
- Back-to-back random: 1000 random a, b, cin pairs with random in_valid/out_ready gaps -> every result equals the reference model {cout,sum}=a+b+cin. No results lost or duplicated.
